// File: rtl/dfd_trace_capture_if.sv
// Trace capture bus: trigger/trace sampling inputs, readout port and status.
// master drives stimulus and readout requests; slave is the capture buffer.
interface dfd_trace_capture_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          trigger;
  logic [DW-1:0] trace;
  logic          arm;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          rd_empty;

  modport master (
    output trigger, trace, arm, rd_req,
    input  rd_data, rd_valid, state, count, rd_empty
  );

  modport slave (
    input  trigger, trace, arm, rd_req,
    output rd_data, rd_valid, state, count, rd_empty
  );
endinterface

// File: rtl/dfd_trace_capture.sv
// Circular debug trace buffer: free-runs while armed, stops POST_TRIG
// samples after a trigger, then reads out oldest-first.
module dfd_trace_capture #(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input logic                clk,
  input logic                reset,
  dfd_trace_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        st_q, st_n;
  logic [AW-1:0] wr_q, wr_n;
  logic [AW-1:0] rd_q, rd_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [AW-1:0] post_q, post_n;
  logic [DW-1:0] rdat_q, rdat_n;
  logic          rv_q, rv_n;
  logic          we;

  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    st_n   = st_q;
    wr_n   = wr_q;
    rd_n   = rd_q;
    cnt_n  = cnt_q;
    post_n = post_q;
    rdat_n = rdat_q;
    rv_n   = 1'b0;
    we     = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.arm) begin
          st_n  = ARMED;
          wr_n  = '0;
          cnt_n = '0;
        end
      end
      ARMED, POST: begin
        we   = 1'b1;
        wr_n = wr_q + 1'b1;
        if (cnt_q != CW'(DEPTH))
          cnt_n = cnt_q + 1'b1;
        if (st_q == ARMED) begin
          if (bus.trigger) begin
            post_n = AW'(POST_TRIG);
            st_n   = POST;
          end
        end else begin
          post_n = post_q - 1'b1;
          if (post_q == AW'(1)) begin
            st_n = DONE;
            // oldest word sits count entries behind the write pointer
            rd_n = wr_n - cnt_n[AW-1:0];
          end
        end
      end
      DONE: begin
        if (bus.arm) begin
          st_n  = ARMED;
          wr_n  = '0;
          cnt_n = '0;
        end else if (bus.rd_req && cnt_q != '0) begin
          rv_n   = 1'b1;
          rdat_n = mem[rd_q];
          rd_n   = rd_q + 1'b1;
          cnt_n  = cnt_q - 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      post_q <= '0;
      rdat_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      st_q   <= st_n;
      wr_q   <= wr_n;
      rd_q   <= rd_n;
      cnt_q  <= cnt_n;
      post_q <= post_n;
      rdat_q <= rdat_n;
      rv_q   <= rv_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset)
      mem[wr_q] <= bus.trace;
  end

  assign bus.rd_data  = rdat_q;
  assign bus.rd_valid = rv_q;
  assign bus.state    = st_q;
  assign bus.count    = cnt_q;
  assign bus.rd_empty = (cnt_q == '0);
endmodule

// File: tb/tb_dfd_trace_capture.sv
// Directed bench for dfd_trace_capture with a readout scoreboard queue.
// Expected words are queued when captures are staged, popped on rd_valid.
module tb_dfd_trace_capture;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int POST_TRIG = 8;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];

  dfd_trace_capture_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  dfd_trace_capture #(
    .DW(DW), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(int first, int n);
    for (int i = 0; i < n; i++)
      sb.push_back(DW'(first + i));
  endtask

  task automatic read_words(string tag, int n, int exp_valid);
    int got;
    got = 0;
    for (int i = 0; i < n; i++) begin
      bus.rd_req = 1'b1;
      step();
      if (bus.rd_valid === 1'b1) begin
        got++;
        if (sb.size() > 0)
          chk({tag, "_rd_data"}, bus.rd_data, sb.pop_front());
      end
    end
    bus.rd_req = 1'b0;
    chk({tag, "_valid_cnt"}, got, exp_valid);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic capture(string tag, int trig_at, bit hold, int exp_cnt);
    bus.arm = 1'b1;
    bus.trigger = hold;
    step();
    bus.arm = 1'b0;
    chk({tag, "_arm_state"}, bus.state, 1);
    chk({tag, "_arm_count"}, bus.count, 0);
    for (int k = 0; k <= trig_at + POST_TRIG; k++) begin
      bus.trace = DW'(32'h100 + k);
      bus.trigger = hold || (k == trig_at);
      step();
      if (k == trig_at + POST_TRIG - 1)
        chk({tag, "_pre_done_state"}, bus.state, 2);
    end
    bus.trigger = hold;
    chk({tag, "_done_state"}, bus.state, 3);
    chk({tag, "_done_count"}, bus.count, exp_cnt);
  endtask

  initial begin
    reset = 1'b1;
    bus.trigger = 1'b0;
    bus.trace = '0;
    bus.arm = 1'b0;
    bus.rd_req = 1'b0;
    step();
    step();
    chk("rst_state", bus.state, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.rd_empty, 1);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_data", bus.rd_data, 0);
    reset = 1'b0;
    step();

    // wrap-around capture, trigger on 20th sample
    capture("wrap", 19, 1'b0, 16);
    push_range(32'h10C, 16);
    read_words("wrap", 16, 16);
    chk("wrap_empty", bus.rd_empty, 1);
    read_words("wrap_extra", 1, 0);
    chk("wrap_hold", bus.rd_data, 32'h11B);

    // early trigger, partial buffer
    capture("early", 1, 1'b0, 10);
    push_range(32'h100, 10);
    read_words("early", 11, 10);
    chk("early_empty", bus.rd_empty, 1);

    // trigger together with arm from IDLE
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("idle_state", bus.state, 0);
    bus.arm = 1'b1;
    bus.trigger = 1'b1;
    step();
    bus.arm = 1'b0;
    bus.trigger = 1'b0;
    chk("armtrig_state", bus.state, 1);
    chk("armtrig_count", bus.count, 0);
    bus.trace = 32'h200;
    step();
    chk("armtrig_s1_state", bus.state, 1);
    chk("armtrig_s1_count", bus.count, 1);

    // reset in the middle of POST
    bus.trigger = 1'b1;
    bus.trace = 32'h201;
    step();
    bus.trigger = 1'b0;
    chk("post_state", bus.state, 2);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("midpost_state", bus.state, 0);
    chk("midpost_count", bus.count, 0);
    chk("midpost_valid", bus.rd_valid, 0);
    chk("midpost_empty", bus.rd_empty, 1);
    chk("midpost_data", bus.rd_data, 0);
    reset = 1'b0;
    read_words("midpost_rd", 2, 0);
    chk("midpost_after_state", bus.state, 0);

    // arm beats rd_req in DONE
    capture("armrd", 1, 1'b0, 10);
    push_range(32'h100, 5);
    read_words("armrd", 5, 5);
    chk("armrd_count5", bus.count, 5);
    bus.arm = 1'b1;
    bus.rd_req = 1'b1;
    step();
    bus.arm = 1'b0;
    bus.rd_req = 1'b0;
    chk("armrd_valid", bus.rd_valid, 0);
    chk("armrd_state", bus.state, 1);
    chk("armrd_count", bus.count, 0);

    // trigger held high throughout
    reset = 1'b1;
    step();
    reset = 1'b0;
    capture("hold", 0, 1'b1, 9);
    step();
    step();
    step();
    chk("hold_stay_state", bus.state, 3);
    chk("hold_stay_count", bus.count, 9);
    push_range(32'h100, 9);
    read_words("hold", 9, 9);
    chk("hold_end_state", bus.state, 3);
    bus.trigger = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
